// File: rtl/bus_arbiter_rr_pkg.sv
// ============================================================================
// Module      : bus_arbiter_rr_pkg
// Description : Shared FSM states, grant-class codes and log-record type for
//               the round-robin bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PROC_GNT  = 2'd1,
        SNOOP_GNT = 2'd2
    } state_t;

    localparam logic [1:0] CLS_PROC  = 2'b01;
    localparam logic [1:0] CLS_SNOOP = 2'b10;

    // Widest requester index supported (16 cores); narrower configs slice it.
    localparam int MAX_ID_W = 4;

    typedef struct packed {
        logic [1:0]          cls;
        logic [MAX_ID_W-1:0] id;
    } log_rec_t;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Round-robin search: first set request after ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    int              w_pos;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_pos  = 0;
        w_cand = '0;
        // Offset N wraps back onto ptr itself, so it is searched last.
        for (int k = 1; k <= N; k++) begin
            w_pos  = (int'(ptr) + k) % N;
            w_cand = ID_W'(w_pos);
            if (!found && req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Two-class (snoop over proc) round-robin bus arbiter with
//               grant logging and bounded proc tenure under snoop pressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = $clog2(NUM_CORES),
    parameter int MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] req_proc,
    input  logic [NUM_CORES-1:0] req_snoop,
    output logic [NUM_CORES-1:0] gnt_proc,
    output logic [NUM_CORES-1:0] gnt_snoop,
    input  logic                 log_full,
    output logic                 log_wr_en,
    output logic [ID_W+1:0]      log_data,
    output logic                 no_snoop
);

    localparam int c_HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int c_HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [NUM_CORES-1:0] c_ONE = NUM_CORES'(1);

    state_t                r_state;
    logic [NUM_CORES-1:0]  r_gnt_proc;
    logic [NUM_CORES-1:0]  r_gnt_snoop;
    logic [ID_W-1:0]       r_proc_ptr;
    logic [ID_W-1:0]       r_snoop_ptr;
    logic [ID_W-1:0]       r_gnt_id;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic                  r_log_wr_en;
    logic [ID_W+1:0]       r_log_data;

    logic                  w_proc_found;
    logic [ID_W-1:0]       w_proc_idx;
    logic                  w_snoop_found;
    logic [ID_W-1:0]       w_snoop_idx;
    logic [ID_W-1:0]       w_win_idx;
    log_rec_t              w_rec;
    logic                  w_snoop_pend;
    logic                  w_preempt;
    logic                  w_no_snoop;
    logic                  w_unused_rec_bits;

    rr_pick #(
        .N    (NUM_CORES),
        .ID_W (ID_W)
    ) u_pick_proc (
        .req   (req_proc),
        .ptr   (r_proc_ptr),
        .found (w_proc_found),
        .idx   (w_proc_idx)
    );

    rr_pick #(
        .N    (NUM_CORES),
        .ID_W (ID_W)
    ) u_pick_snoop (
        .req   (req_snoop),
        .ptr   (r_snoop_ptr),
        .found (w_snoop_found),
        .idx   (w_snoop_idx)
    );

    always_comb begin
        w_win_idx = w_snoop_found ? w_snoop_idx : w_proc_idx;
        w_rec.cls = w_snoop_found ? CLS_SNOOP : CLS_PROC;
        w_rec.id  = MAX_ID_W'(w_win_idx);
    end

    assign w_unused_rec_bits = ^w_rec;

    assign w_snoop_pend = |req_snoop;
    assign w_preempt    = (MAX_HOLD > 0) && w_snoop_pend &&
                          (r_hold_cnt == c_HOLD_W'(c_HOLD_LAST));

    // Written so an unknown req_snoop resolves to "snoop pending".
    always_comb begin
        if ((req_snoop == '0) && (r_gnt_snoop == '0)) begin
            w_no_snoop = 1'b1;
        end else begin
            w_no_snoop = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt_proc  <= '0;
            r_gnt_snoop <= '0;
            r_proc_ptr  <= ID_W'(NUM_CORES - 1);
            r_snoop_ptr <= ID_W'(NUM_CORES - 1);
            r_gnt_id    <= '0;
            r_hold_cnt  <= '0;
            r_log_wr_en <= 1'b0;
            r_log_data  <= '0;
        end else begin
            r_log_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_hold_cnt <= '0;
                    if (!log_full && (w_snoop_found || w_proc_found)) begin
                        r_gnt_id    <= w_win_idx;
                        r_log_wr_en <= 1'b1;
                        r_log_data  <= {w_rec.cls, w_rec.id[ID_W-1:0]};
                        if (w_snoop_found) begin
                            r_state     <= SNOOP_GNT;
                            r_gnt_snoop <= c_ONE << w_snoop_idx;
                            r_snoop_ptr <= w_snoop_idx;
                        end else begin
                            r_state    <= PROC_GNT;
                            r_gnt_proc <= c_ONE << w_proc_idx;
                            r_proc_ptr <= w_proc_idx;
                        end
                    end
                end
                PROC_GNT: begin
                    if (!req_proc[r_gnt_id] || w_preempt) begin
                        r_state    <= IDLE;
                        r_gnt_proc <= '0;
                        r_hold_cnt <= '0;
                    end else if ((MAX_HOLD > 0) && w_snoop_pend) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                SNOOP_GNT: begin
                    if (!req_snoop[r_gnt_id]) begin
                        r_state     <= IDLE;
                        r_gnt_snoop <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt_proc  <= '0;
                    r_gnt_snoop <= '0;
                end
            endcase
        end
    end

    assign gnt_proc  = r_gnt_proc;
    assign gnt_snoop = r_gnt_snoop;
    assign log_wr_en = r_log_wr_en;
    assign log_data  = r_log_data;
    assign no_snoop  = w_no_snoop;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
// ============================================================================
// Module      : tb_bus_arbiter_rr
// Description : Self-checking bench for bus_arbiter_rr (4 cores, MAX_HOLD=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_proc;
    logic [N-1:0]  req_snoop;
    logic [N-1:0]  gnt_proc;
    logic [N-1:0]  gnt_snoop;
    logic          log_full;
    logic          log_wr_en;
    logic [IW+1:0] log_data;
    logic          no_snoop;

    int checks = 0;
    int errors = 0;
    logic [IW+1:0] exp_q[$];

    typedef struct {
        logic [3:0] rp;
        logic [3:0] rs;
        logic       lf;
        logic [3:0] gp;
        logic [3:0] gs;
        logic       wr;
        logic [5:0] ld;
        logic       ns;
    } vec_t;

    vec_t vecs[$];

    bus_arbiter_rr #(
        .NUM_CORES (N),
        .ID_W      (IW),
        .MAX_HOLD  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_proc  (req_proc),
        .req_snoop (req_snoop),
        .gnt_proc  (gnt_proc),
        .gnt_snoop (gnt_snoop),
        .log_full  (log_full),
        .log_wr_en (log_wr_en),
        .log_data  (log_data),
        .no_snoop  (no_snoop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] rp, input logic [3:0] rs, input logic lf,
                       input logic [3:0] gp, input logic [3:0] gs, input logic wr,
                       input logic [5:0] ld, input logic ns);
        vec_t v;
        v.rp = rp; v.rs = rs; v.lf = lf; v.gp = gp; v.gs = gs;
        v.wr = wr; v.ld = ld; v.ns = ns;
        vecs.push_back(v);
    endtask

    // Log monitor: every write strobe must match the oldest expected record.
    always @(negedge clk) begin
        chk("grant_onehot", 32'($countones(gnt_proc | gnt_snoop) <= 1), 32'd1);
        if (log_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_log_write: got %0h expected no write", log_data);
            end else begin
                chk("log_record", 32'(log_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // rp, rs, lf | gp, gs, wr, log_data, no_snoop
        add(4'b1010, 4'b0000, 0, 4'b0010, 4'b0000, 1, 6'b01_01, 1);
        add(4'b1010, 4'b0000, 0, 4'b0010, 4'b0000, 0, 6'b01_01, 1);
        add(4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b01_01, 1);
        add(4'b1000, 4'b0000, 0, 4'b1000, 4'b0000, 1, 6'b01_11, 1);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b01_11, 1);
        add(4'b1111, 4'b0000, 0, 4'b0001, 4'b0000, 1, 6'b01_00, 1);
        add(4'b1111, 4'b0000, 0, 4'b0001, 4'b0000, 0, 6'b01_00, 1);
        add(4'b1110, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b01_00, 1);
        add(4'b1111, 4'b0000, 0, 4'b0010, 4'b0000, 1, 6'b01_01, 1);
        add(4'b1111, 4'b0000, 0, 4'b0010, 4'b0000, 0, 6'b01_01, 1);
        add(4'b1101, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b01_01, 1);
        add(4'b1111, 4'b0000, 0, 4'b0100, 4'b0000, 1, 6'b01_10, 1);
        add(4'b1111, 4'b0000, 0, 4'b0100, 4'b0000, 0, 6'b01_10, 1);
        add(4'b1011, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b01_10, 1);
        add(4'b1111, 4'b0000, 0, 4'b1000, 4'b0000, 1, 6'b01_11, 1);
        add(4'b1111, 4'b0000, 0, 4'b1000, 4'b0000, 0, 6'b01_11, 1);
        add(4'b0111, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b01_11, 1);
        add(4'b1111, 4'b0000, 0, 4'b0001, 4'b0000, 1, 6'b01_00, 1);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b01_00, 1);
        // simultaneous proc/snoop: snoop first
        add(4'b0001, 4'b0100, 0, 4'b0000, 4'b0100, 1, 6'b10_10, 0);
        add(4'b0001, 4'b0100, 0, 4'b0000, 4'b0100, 0, 6'b10_10, 0);
        add(4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b10_10, 1);
        add(4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 1, 6'b01_00, 1);
        add(4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 0, 6'b01_00, 1);
        // hold limit: snoop 3 pending forces proc 0 off after 4 cycles
        add(4'b0001, 4'b1000, 0, 4'b0001, 4'b0000, 0, 6'b01_00, 0);
        add(4'b0001, 4'b1000, 0, 4'b0001, 4'b0000, 0, 6'b01_00, 0);
        add(4'b0001, 4'b1000, 0, 4'b0001, 4'b0000, 0, 6'b01_00, 0);
        add(4'b0001, 4'b1000, 0, 4'b0000, 4'b0000, 0, 6'b01_00, 0);
        add(4'b0001, 4'b1000, 0, 4'b0000, 4'b1000, 1, 6'b10_11, 0);
        add(4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b10_11, 1);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b10_11, 1);
        // log_full blocks new grants only
        add(4'b0100, 4'b0010, 1, 4'b0000, 4'b0000, 0, 6'b10_11, 0);
        add(4'b0100, 4'b0010, 1, 4'b0000, 4'b0000, 0, 6'b10_11, 0);
        add(4'b0100, 4'b0010, 0, 4'b0000, 4'b0010, 1, 6'b10_01, 0);
        add(4'b0100, 4'b0010, 1, 4'b0000, 4'b0010, 0, 6'b10_01, 0);
        add(4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0, 6'b10_01, 1);
        add(4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0, 6'b10_01, 1);
        add(4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 1, 6'b01_10, 1);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 6'b01_10, 1);

        rst       = 1'b1;
        req_proc  = '0;
        req_snoop = '0;
        log_full  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_gnt_proc",  32'(gnt_proc),  32'h0);
        chk("reset_gnt_snoop", 32'(gnt_snoop), 32'h0);
        chk("reset_log_wr_en", 32'(log_wr_en), 32'h0);
        chk("reset_log_data",  32'(log_data),  32'h0);
        chk("reset_no_snoop",  32'(no_snoop),  32'h1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req_proc  = vecs[i].rp;
            req_snoop = vecs[i].rs;
            log_full  = vecs[i].lf;
            if (vecs[i].wr) exp_q.push_back(vecs[i].ld);
            @(negedge clk);
            chk($sformatf("v%0d_gnt_proc", i),  32'(gnt_proc),  32'(vecs[i].gp));
            chk($sformatf("v%0d_gnt_snoop", i), 32'(gnt_snoop), 32'(vecs[i].gs));
            chk($sformatf("v%0d_log_wr_en", i), 32'(log_wr_en), 32'(vecs[i].wr));
            chk($sformatf("v%0d_log_data", i),  32'(log_data),  32'(vecs[i].ld));
            chk($sformatf("v%0d_no_snoop", i),  32'(no_snoop),  32'(vecs[i].ns));
        end

        // Reset in the middle of a snoop grant, then first grant goes to 0.
        req_snoop = 4'b0100;
        exp_q.push_back(6'b10_10);
        @(negedge clk);
        chk("mid_gnt_snoop_on", 32'(gnt_snoop), 32'h4);
        @(negedge clk);
        chk("mid_gnt_snoop_held", 32'(gnt_snoop), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt_proc",  32'(gnt_proc),  32'h0);
        chk("async_rst_gnt_snoop", 32'(gnt_snoop), 32'h0);
        chk("async_rst_log_wr_en", 32'(log_wr_en), 32'h0);
        chk("async_rst_log_data",  32'(log_data),  32'h0);
        chk("async_rst_no_snoop",  32'(no_snoop),  32'h0);
        @(negedge clk);
        rst       = 1'b0;
        req_snoop = 4'b1111;
        exp_q.push_back(6'b10_00);
        @(negedge clk);
        chk("post_rst_gnt_snoop", 32'(gnt_snoop), 32'h1);
        chk("post_rst_log_wr_en", 32'(log_wr_en), 32'h1);
        chk("post_rst_log_data",  32'(log_data),  32'(6'b10_00));
        req_snoop = '0;
        @(negedge clk);
        chk("post_rst_release", 32'(gnt_snoop), 32'h0);
        @(negedge clk);
        chk("log_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
